// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding APB3/APB4 initiator behind a
// valid/ready request/response port. One transfer at a time through
// IDLE -> SETUP -> ACCESS -> RESP; every bus and response output is registered.
// Optional build macro APB_TIMEOUT_EN: abort an ACCESS phase that has waited
// TIMEOUT_CYCLES cycles without out_pready, returning resp_err = 1.
module apb_master_bridge #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [3:0]        req_wstrb,
  input  logic [2:0]        req_prot,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] out_paddr,
  output logic              out_psel,
  output logic              out_penable,
  output logic [2:0]        out_pprot,
  output logic              out_pwrite,
  output logic [DATA_W-1:0] out_pwdata,
  output logic [3:0]        out_pstrb,
  input  logic              out_pready,
  input  logic [DATA_W-1:0] out_prdata,
  input  logic              out_pslverr
);

  // pstrb is fixed at 4 bits, so only 32-bit data is meaningful
  if (DATA_W != 32) begin : g_bad_data_w
    $error("apb_master_bridge: DATA_W must be 32");
  end
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("apb_master_bridge: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic [2:0]          pprot_q, pprot_d;
  logic                pwrite_q, pwrite_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [3:0]          pstrb_q, pstrb_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic                resp_err_q, resp_err_d;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                  $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt_q + CNT_W'(1);
`endif

  // Requests are only taken in IDLE while reset is released
  assign req_ready   = (state_q == S_IDLE) && reset;

  assign out_paddr   = paddr_q;
  assign out_psel    = psel_q;
  assign out_penable = penable_q;
  assign out_pprot   = pprot_q;
  assign out_pwrite  = pwrite_q;
  assign out_pwdata  = pwdata_q;
  assign out_pstrb   = pstrb_q;
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_err    = resp_err_q;

  // Next-state and registered-output logic; everything holds unless changed
  always_comb begin
    state_d      = state_q;
    paddr_d      = paddr_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pprot_d      = pprot_q;
    pwrite_d     = pwrite_q;
    pwdata_d     = pwdata_q;
    pstrb_d      = pstrb_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
`ifdef APB_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          paddr_d   = req_addr;
          pwrite_d  = req_write;
          pprot_d   = req_prot;
          pwdata_d  = req_write ? req_wdata : '0;
          pstrb_d   = req_write ? req_wstrb : '0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = S_SETUP;
        end
      end

      S_SETUP: begin
        penable_d = 1'b1;
        state_d   = S_ACCESS;
`ifdef APB_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end

      S_ACCESS: begin
        // pready has priority over a timeout expiring on the same edge
        if (out_pready) begin
          psel_d       = 1'b0;
          penable_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_rdata_d = pwrite_q ? '0 : out_prdata;
          resp_err_d   = out_pslverr;
          state_d      = S_RESP;
        end
`ifdef APB_TIMEOUT_EN
        else if (cnt_inc == TO_LIMIT) begin
          psel_d       = 1'b0;
          penable_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_rdata_d = '0;
          resp_err_d   = 1'b1;
          state_d      = S_RESP;
        end else begin
          cnt_d = cnt_inc;
        end
`endif
      end

      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      paddr_q      <= '0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pprot_q      <= '0;
      pwrite_q     <= 1'b0;
      pwdata_q     <= '0;
      pstrb_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      paddr_q      <= paddr_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pprot_q      <= pprot_d;
      pwrite_q     <= pwrite_d;
      pwdata_q     <= pwdata_d;
      pstrb_q      <= pstrb_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
`ifdef APB_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Single-outstanding APB initiator that converts a valid/ready request/response interface into APB3/APB4 transfers.
- Sits between the CPU-side memory interface and APB peripherals such as the GPIO, UART and timer blocks.
- Runs one transfer at a time. Owns the SETUP/ACCESS sequencing, wait-state handling and error return.

Parameters:
- ADDR_W, 32, width of request address and out_paddr
- DATA_W, 32, width of write/read data; must be 32 (pstrb is 4 bits)
- TIMEOUT_CYCLES, 255, ACCESS-phase cycles before abort; only used with APB_TIMEOUT_EN

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset (0 = reset)
- req_valid  in  1  request present
- req_ready  out  1  bridge can accept a request
- req_addr  in  ADDR_W  byte address
- req_write  in  1  1 = write, 0 = read
- req_wdata  in  DATA_W  write data
- req_wstrb  in  4  byte strobes
- req_prot  in  3  protection attributes
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  DATA_W  read data (0 for writes)
- resp_err  out  1  transfer error (pslverr or timeout)
- out_paddr  out  ADDR_W  APB address
- out_psel  out  1  APB select
- out_penable  out  1  APB enable
- out_pprot  out  3  APB protection
- out_pwrite  out  1  APB direction
- out_pwdata  out  DATA_W  APB write data
- out_pstrb  out  4  APB strobes
- out_pready  in  1  completer ready
- out_prdata  in  DATA_W  completer read data
- out_pslverr  in  1  completer error

Behaviour:
- States: IDLE, SETUP, ACCESS, RESP. All state and outputs are registered.
- Reset is sampled on the clock edge only. Asserting reset in any state forces the following on the next edge:
  - state = IDLE
  - out_psel = out_penable = 0, out_pwrite = 0
  - out_paddr = out_pwdata = 0, out_pstrb = 0, out_pprot = 0
  - resp_valid = 0, resp_rdata = 0, resp_err = 0
  - An in-flight transfer is dropped; no response is produced for it.
- req_ready = 1 only in IDLE and out of reset (combinational from state).
- IDLE:
  - On req_valid & req_ready, latch addr, write, wdata, wstrb and prot into the out_p* registers.
  - For reads, out_pwdata = 0 and out_pstrb = 0.
  - Go to SETUP.
- SETUP: out_psel = 1, out_penable = 0, for exactly one cycle, then go to ACCESS.
- ACCESS:
  - out_psel = 1, out_penable = 1.
  - out_paddr, out_pwrite, out_pwdata, out_pstrb and out_pprot are held stable.
  - Remain in ACCESS while out_pready = 0 (unbounded without the option).
  - On out_pready = 1:
    - resp_rdata = out_prdata for a read, 0 for a write.
    - resp_err = out_pslverr.
    - out_psel and out_penable drop to 0 on the same edge.
    - resp_valid = 1; go to RESP.
- RESP:
  - resp_valid, resp_rdata and resp_err are held until resp_ready = 1.
  - On the handshake edge, resp_valid = 0 and state = IDLE.
  - req_ready rises in the cycle after the handshake; no back-to-back overlap.
- Latency: accept edge N → SETUP in cycle N+1 → ACCESS in N+2. With zero wait states, resp_valid rises at N+3. Each wait state adds one cycle.
- The bridge never drives out_psel high outside SETUP/ACCESS and never asserts out_penable without out_psel.
- out_pslverr and out_prdata are ignored unless out_pready = 1 in ACCESS.
- Address and strobes pass through unmodified; no alignment check.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- When defined:
  - An 8+-bit counter clears on entry to ACCESS and increments each ACCESS cycle with out_pready = 0.
  - If it reaches TIMEOUT_CYCLES, the bridge:
    - deasserts out_psel and out_penable;
    - sets resp_valid = 1, resp_err = 1, resp_rdata = 0;
    - goes to RESP.
  - A pready arriving on the same edge as the timeout wins: it is a normal completion.
- When undefined: no counter, and ACCESS waits indefinitely for out_pready.

Test Plan:
- Write, zero wait: req addr 0x10002000, wdata 0x0000ABCD, wstrb 0xF, with pready held 1 → psel/penable = 10 then 11 at cycles N+1/N+2; resp_valid at N+3 with resp_err = 0 and resp_rdata = 0; completer sees 0xABCD.
- Read, 3 wait states: addr 0x10002004; pready rises after 3 ACCESS cycles with prdata 0x00005A5A → resp_valid at N+6; resp_rdata = 0x00005A5A; pwdata = 0 and pstrb = 0 throughout; addr stable across all ACCESS cycles.
- Slave error: write to 0x1000200C with pslverr = 1 at pready → resp_err = 1, and the next request is accepted normally.
- Response backpressure: resp_ready held 0 for 5 cycles after resp_valid → resp fields stable, req_ready = 0, psel = 0; after the handshake, req_ready = 1 on the next cycle.
- Reset mid-ACCESS: drive reset = 0 while in ACCESS with pready = 0 → next edge psel = 0, penable = 0, resp_valid = 0, req_ready = 1 after release; no stray response.
- APB_TIMEOUT_EN with TIMEOUT_CYCLES = 4: pready held 0 → abort after 4 ACCESS cycles with resp_err = 1 and resp_rdata = 0; repeat with pready = 1 on the 4th cycle → normal completion with resp_err = 0.
